seg7_scan_decoder: RTL and testbench

Receive-side counterpart of the multiplexed 4-digit seven-segment display driver. Samples the scanned SEG/DIGIT bus and inverts segment patterns back to BCD. Reassembles complete 4-digit frames (units..thousands). Used as a self-check monitor on the counter/display path, or to read an external scanned display into the fabric.

---
 rtl/seg7_scan_decoder.sv | 217 +++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Receive-side decoder for a multiplexed 4-digit seven-segment bus.
// Samples SEG/DIGIT, debounces each digit activation, maps segment patterns
// back to BCD and publishes complete units..thousands frames.
module seg7_scan_decoder #(
   parameter int unsigned STABLE_CYCLES    = 16,
   parameter int unsigned TIMEOUT_CYCLES   = 1000000,
   parameter bit          SEG_ACTIVE_LOW   = 1'b1,
   parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [7:0] SEG,
   input  logic [3:0] DIGIT,
   output logic [3:0] units,
   output logic [3:0] tens,
   output logic [3:0] hundreds,
   output logic [3:0] thousands,
   output logic       frame_valid,
   output logic       value_changed,
   output logic       decode_err,
   output logic       frame_lost
);

   localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned IDLE_W = 20;
   localparam logic [CNT_W-1:0]  STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
   localparam logic [6:0] SEG_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [3:0] DIG_IDLE = DIGIT_ACTIVE_LOW ? 4'hF : 4'h0;

   typedef enum logic [1:0] {
      WAIT_SEL = 2'd0,
      SETTLE   = 2'd1,
      HOLD     = 2'd2
   } state_t;

   // Decimal point carries no digit information
   logic unused_dp;
   assign unused_dp = SEG[7];

   logic [6:0] seg_s1, seg_s2;
   logic [3:0] dig_s1, dig_s2;
   logic [6:0] seg_n;
   logic [3:0] dig_n;

   state_t           state, state_nxt;
   logic [6:0]       cand_seg;
   logic [3:0]       cand_dig;
   logic [CNT_W-1:0] stab_cnt;
   logic             cand_load_c, stab_inc_c, accept_c, match_c;

   logic [3:0][3:0]  slot;
   logic [3:0]       seen, seen_nxt;
   logic             err_pend, err_nxt;
   logic [IDLE_W-1:0] idle_cnt;
   logic [1:0]       acc_idx;
   logic [4:0]       dec;
   logic             frame_done_c, timeout_c;

   // Map a lit-segment pattern to {valid, bcd}
   function automatic logic [4:0] decode_seg(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'h3F:   r = 5'h10;
         7'h06:   r = 5'h11;
         7'h5B:   r = 5'h12;
         7'h4F:   r = 5'h13;
         7'h66:   r = 5'h14;
         7'h6D:   r = 5'h15;
         7'h7D:   r = 5'h16;
         7'h07:   r = 5'h17;
         7'h7F:   r = 5'h18;
         7'h6F:   r = 5'h19;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   // One-hot digit select to slot index
   function automatic logic [1:0] slot_idx(input logic [3:0] d);
      logic [1:0] r;
      case (d)
         4'b0010: r = 2'd1;
         4'b0100: r = 2'd2;
         4'b1000: r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

   // Two-flop synchronisers on the scanned bus
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         seg_s1 <= SEG_IDLE;
         seg_s2 <= SEG_IDLE;
         dig_s1 <= DIG_IDLE;
         dig_s2 <= DIG_IDLE;
      end else begin
         seg_s1 <= SEG[6:0];
         seg_s2 <= seg_s1;
         dig_s1 <= DIGIT;
         dig_s2 <= dig_s1;
      end
   end

   assign seg_n = SEG_ACTIVE_LOW   ? ~seg_s2 : seg_s2;
   assign dig_n = DIGIT_ACTIVE_LOW ? ~dig_s2 : dig_s2;

   // Debounce FSM: next state and control strobes
   always_comb begin
      state_nxt   = state;
      cand_load_c = 1'b0;
      stab_inc_c  = 1'b0;
      accept_c    = 1'b0;
      match_c     = ({seg_n, dig_n} == {cand_seg, cand_dig});
      case (state)
         WAIT_SEL: begin
            if ($onehot(dig_n)) begin
               cand_load_c = 1'b1;
               state_nxt   = SETTLE;
            end
         end
         SETTLE: begin
            if (match_c) begin
               if (stab_cnt == STAB_LAST) begin
                  accept_c  = 1'b1;
                  state_nxt = HOLD;
               end else begin
                  stab_inc_c = 1'b1;
               end
            end else if ($onehot(dig_n)) begin
               cand_load_c = 1'b1;
            end else begin
               state_nxt = WAIT_SEL;
            end
         end
         HOLD: begin
            if (!match_c) state_nxt = WAIT_SEL;
         end
         default: state_nxt = WAIT_SEL;
      endcase
   end

   // FSM state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= WAIT_SEL;
      else        state <= state_nxt;
   end

   // Candidate sample and stability counter
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cand_seg <= 7'h00;
         cand_dig <= 4'h0;
         stab_cnt <= '0;
      end else if (cand_load_c) begin
         cand_seg <= seg_n;
         cand_dig <= dig_n;
         stab_cnt <= CNT_W'(1);
      end else if (stab_inc_c) begin
         stab_cnt <= stab_cnt + CNT_W'(1);
      end
   end

   // Frame bookkeeping: completion, timeout and slot accept
   always_comb begin
      acc_idx      = slot_idx(cand_dig);
      dec          = decode_seg(cand_seg);
      frame_done_c = (seen == 4'b1111);
      timeout_c    = (idle_cnt == IDLE_LAST);
      seen_nxt     = (frame_done_c || timeout_c) ? 4'b0000 : seen;
      err_nxt      = (frame_done_c || timeout_c) ? 1'b0 : err_pend;
      if (accept_c) begin
         seen_nxt[acc_idx] = 1'b1;
         err_nxt           = err_nxt | ~dec[4];
      end
   end

   // Slots, idle counter and registered outputs
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         slot          <= '0;
         seen          <= 4'b0000;
         err_pend      <= 1'b0;
         idle_cnt      <= '0;
         units         <= 4'h0;
         tens          <= 4'h0;
         hundreds      <= 4'h0;
         thousands     <= 4'h0;
         frame_valid   <= 1'b0;
         value_changed <= 1'b0;
         decode_err    <= 1'b0;
         frame_lost    <= 1'b0;
      end else begin
         frame_valid   <= 1'b0;
         value_changed <= 1'b0;
         frame_lost    <= 1'b0;
         seen          <= seen_nxt;
         err_pend      <= err_nxt;
         if (accept_c) slot[acc_idx] <= dec[4] ? dec[3:0] : 4'h0;
         if (accept_c || timeout_c) idle_cnt <= '0;
         else                       idle_cnt <= idle_cnt + IDLE_W'(1);
         if (frame_done_c) begin
            units         <= slot[0];
            tens          <= slot[1];
            hundreds      <= slot[2];
            thousands     <= slot[3];
            frame_valid   <= 1'b1;
            value_changed <= (slot != {thousands, hundreds, tens, units});
            decode_err    <= err_pend;
         end else if (timeout_c) begin
            frame_lost <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with an active-low scanned bus.
module tb_seg7_scan_decoder;

   localparam int unsigned STABLE = 16;
   localparam int unsigned TMO    = 1500;

   logic       CLK;
   logic       RST_N;
   logic [7:0] SEG;
   logic [3:0] DIGIT;
   logic [3:0] units, tens, hundreds, thousands;
   logic       frame_valid, value_changed, decode_err, frame_lost;

   int   n_vec    = 0;
   int   n_err    = 0;
   int   fv_cnt   = 0;
   int   fl_cnt   = 0;
   int   stray_vc = 0;
   logic last_vc  = 1'b0;
   int   f0, l0;
   logic [6:0] gp [4];

   seg7_scan_decoder #(
      .STABLE_CYCLES   (STABLE),
      .TIMEOUT_CYCLES  (TMO),
      .SEG_ACTIVE_LOW  (1'b1),
      .DIGIT_ACTIVE_LOW(1'b1)
   ) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .SEG          (SEG),
      .DIGIT        (DIGIT),
      .units        (units),
      .tens         (tens),
      .hundreds     (hundreds),
      .thousands    (thousands),
      .frame_valid  (frame_valid),
      .value_changed(value_changed),
      .decode_err   (decode_err),
      .frame_lost   (frame_lost)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Pulse counters sampled away from the active edge
   always @(negedge CLK) begin
      if (frame_valid === 1'b1) begin
         fv_cnt++;
         last_vc = value_changed;
      end
      if (frame_lost === 1'b1) fl_cnt++;
      if (value_changed === 1'b1 && frame_valid !== 1'b1) stray_vc++;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      SEG   = 8'hFF;
      DIGIT = 4'hF;
      repeat (n) @(negedge CLK);
   endtask

   task automatic show(input int idx, input logic [6:0] pat, input int n);
      SEG   = {1'b1, ~pat};
      DIGIT = ~(4'b0001 << idx);
      repeat (n) @(negedge CLK);
   endtask

   task automatic scan(input logic [6:0] u, input logic [6:0] t,
                       input logic [6:0] h, input logic [6:0] th);
      show(0, u, 64);
      show(1, t, 64);
      show(2, h, 64);
      show(3, th, 64);
      idle(30);
   endtask

   function automatic logic [15:0] shown();
      return {thousands, hundreds, tens, units};
   endfunction

   initial begin
      RST_N = 1'b0;
      SEG   = 8'hFF;
      DIGIT = 4'hF;
      repeat (3) @(negedge CLK);
      check("reset_value", shown(), 16'h0000);
      check("reset_flags", {12'h0, frame_valid, value_changed, decode_err, frame_lost}, 16'h0000);
      RST_N = 1'b1;
      idle(5);

      // First 1234 frame
      f0 = fv_cnt;
      scan(7'h66, 7'h4F, 7'h5B, 7'h06);
      check("f1234_count", 16'(fv_cnt - f0), 16'd1);
      check("f1234_value", shown(), 16'h1234);
      check("f1234_changed", {15'h0, last_vc}, 16'h0001);
      check("f1234_err", {15'h0, decode_err}, 16'h0000);

      // Identical frame again
      f0 = fv_cnt;
      scan(7'h66, 7'h4F, 7'h5B, 7'h06);
      check("rep_count", 16'(fv_cnt - f0), 16'd1);
      check("rep_changed", {15'h0, last_vc}, 16'h0000);

      // Every pattern one cycle short of stable
      gp[0] = 7'h66; gp[1] = 7'h4F; gp[2] = 7'h5B; gp[3] = 7'h06;
      f0 = fv_cnt;
      l0 = fl_cnt;
      for (int r = 0; r < 4; r++)
         for (int d = 0; d < 4; d++)
            show(d, gp[d], STABLE - 1);
      idle(2);
      check("glitch_no_frame", 16'(fv_cnt - f0), 16'd0);
      check("glitch_no_lost", 16'(fl_cnt - l0), 16'd0);
      idle(TMO);
      check("timeout_lost", 16'(fl_cnt - l0), 16'd1);
      check("timeout_no_frame", 16'(fv_cnt - f0), 16'd0);
      check("timeout_hold", shown(), 16'h1234);

      // 9876 with an undecodable tens pattern
      f0 = fv_cnt;
      scan(7'h7D, 7'h49, 7'h7F, 7'h6F);
      check("bad_count", 16'(fv_cnt - f0), 16'd1);
      check("bad_value", shown(), 16'h9806);
      check("bad_err", {15'h0, decode_err}, 16'h0001);

      // Clean 9876 clears the error
      f0 = fv_cnt;
      scan(7'h7D, 7'h07, 7'h7F, 7'h6F);
      check("clean_count", 16'(fv_cnt - f0), 16'd1);
      check("clean_value", shown(), 16'h9876);
      check("clean_err", {15'h0, decode_err}, 16'h0000);
      check("clean_changed", {15'h0, last_vc}, 16'h0001);

      // Multi-hot select is ignored
      f0 = fv_cnt;
      SEG   = {1'b1, ~7'h3F};
      DIGIT = 4'b1100;
      repeat (100) @(negedge CLK);
      idle(30);
      check("multihot_ignored", 16'(fv_cnt - f0), 16'd0);
      scan(7'h3F, 7'h3F, 7'h3F, 7'h3F);
      check("zero_count", 16'(fv_cnt - f0), 16'd1);
      check("zero_value", shown(), 16'h0000);
      check("zero_changed", {15'h0, last_vc}, 16'h0001);

      // Leave a nonzero value with an error flagged before the reset test
      scan(7'h7D, 7'h49, 7'h7F, 7'h6F);
      check("pre_reset_value", shown(), 16'h9806);

      // Reset in the middle of a 5555 frame
      show(0, 7'h6D, 64);
      show(1, 7'h6D, 64);
      #2 RST_N = 1'b0;
      #1;
      check("midreset_value", shown(), 16'h0000);
      check("midreset_err", {15'h0, decode_err}, 16'h0000);
      idle(3);
      RST_N = 1'b1;
      f0 = fv_cnt;
      show(2, 7'h6D, 64);
      show(3, 7'h6D, 64);
      idle(30);
      check("partial_discarded", 16'(fv_cnt - f0), 16'd0);
      show(0, 7'h6D, 64);
      show(1, 7'h6D, 64);
      idle(30);
      check("fresh_count", 16'(fv_cnt - f0), 16'd1);
      check("fresh_value", shown(), 16'h5555);
      check("fresh_changed", {15'h0, last_vc}, 16'h0001);

      check("stray_changed", 16'(stray_vc), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
